// File: rtl/load_store_unit_if.sv
// load_store_unit_if: pipeline request/response and word-only data_memory port of the load/store unit
//   master : pipeline + memory side (drives requests and mem_rdata)
//   slave  : load_store_unit side (drives stall, response and memory strobes)
interface load_store_unit_if;
   logic        req_valid;
   logic        req_we;
   logic        req_unsigned;
   logic [1:0]  req_size;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        stall;
   logic        rsp_valid;
   logic        misalign;
   logic [31:0] rsp_rdata;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] mem_adr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   modport master (
      output req_valid, req_we, req_unsigned, req_size, req_addr, req_wdata, mem_rdata,
      input  stall, rsp_valid, misalign, rsp_rdata, mem_read, mem_write, mem_adr, mem_wdata
   );
   modport slave (
      input  req_valid, req_we, req_unsigned, req_size, req_addr, req_wdata, mem_rdata,
      output stall, rsp_valid, misalign, rsp_rdata, mem_read, mem_write, mem_adr, mem_wdata
   );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: MEM-stage initiator turning byte/half/word loads and stores into word accesses
//   clk : clock, all state on posedge
//   rst : asynchronous active-high reset
//   lsu : slave side of load_store_unit_if (request in, stall/response out, data_memory strobes)
module load_store_unit #(
   parameter int WAIT_CYCLES = 0,
   parameter int ALIGN_CHECK = 1
) (
   input logic              clk,
   input logic              rst,
   load_store_unit_if.slave lsu
);
   localparam int CW = WAIT_CYCLES > 0 ? $clog2(WAIT_CYCLES + 1) : 1;
   typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;
   state_t      r_state;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [31:0] r_buf;
   logic [31:0] r_rdata;
   logic [1:0]  r_size;
   logic        r_we;
   logic        r_uns;
   logic        r_mis;
   logic [CW-1:0] r_cnt;
   logic        w_mis;
   logic        w_last;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_ext;
   logic [31:0] w_merged;

   // size 11 counts as word, so req_size[1] selects word handling everywhere
   assign w_mis  = (ALIGN_CHECK != 0) &&
                   ((lsu.req_size == 2'b01 && lsu.req_addr[0]) ||
                    (lsu.req_size[1] && lsu.req_addr[1:0] != 2'b00));
   assign w_last = r_cnt == CW'(WAIT_CYCLES);

   // load data is extracted from the word as it enters r_buf, so it is ready in DONE
   assign w_byte = lsu.mem_rdata[{r_addr[1:0], 3'b000} +: 8];
   assign w_half = lsu.mem_rdata[{r_addr[1], 4'b0000} +: 16];
   assign w_ext  = r_size[1] ? lsu.mem_rdata :
                   r_size[0] ? {{16{w_half[15] & ~r_uns}}, w_half} :
                               {{24{w_byte[7] & ~r_uns}}, w_byte};

   always_comb begin
      w_merged = r_buf;
      if (r_size[1]) w_merged = r_wdata;
      else if (r_size[0]) w_merged[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
      else w_merged[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_addr  <= '0;
         r_wdata <= '0;
         r_buf   <= '0;
         r_rdata <= '0;
         r_size  <= '0;
         r_we    <= 1'b0;
         r_uns   <= 1'b0;
         r_mis   <= 1'b0;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            IDLE: if (lsu.req_valid) begin
               r_addr  <= lsu.req_addr;
               r_wdata <= lsu.req_wdata;
               r_size  <= lsu.req_size;
               r_we    <= lsu.req_we;
               r_uns   <= lsu.req_unsigned;
               r_mis   <= w_mis;
               r_cnt   <= '0;
               if (w_mis) begin
                  r_rdata <= '0;
                  r_state <= DONE;
               end else r_state <= (lsu.req_we && lsu.req_size[1]) ? WR : RD;
            end
            RD: if (w_last) begin
               r_buf   <= lsu.mem_rdata;
               r_cnt   <= '0;
               r_state <= r_we ? WR : DONE;
               if (!r_we) r_rdata <= w_ext;
            end else r_cnt <= r_cnt + CW'(1);
            WR: if (w_last) begin
               r_rdata <= '0;
               r_state <= DONE;
            end else r_cnt <= r_cnt + CW'(1);
            default: r_state <= IDLE;
         endcase
      end
   end

   // stall drops in DONE so the pipeline advances exactly once per request
   assign lsu.stall     = (r_state == IDLE && lsu.req_valid) || r_state == RD || r_state == WR;
   assign lsu.rsp_valid = r_state == DONE;
   assign lsu.misalign  = r_state == DONE && r_mis;
   assign lsu.rsp_rdata = r_rdata;
   assign lsu.mem_read  = r_state == RD;
   assign lsu.mem_write = r_state == WR;
   assign lsu.mem_adr   = {r_addr[31:2], 2'b00};
   assign lsu.mem_wdata = w_merged;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: two LSU instances (default, and WAIT_CYCLES=2/ALIGN_CHECK=0) against a word-array memory and reference model
module tb_load_store_unit;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   load_store_unit_if if0 ();
   load_store_unit_if if1 ();
   load_store_unit u0 (.clk(clk), .rst(rst), .lsu(if0));
   load_store_unit #(.WAIT_CYCLES(2), .ALIGN_CHECK(0)) u1 (.clk(clk), .rst(rst), .lsu(if1));

   logic [31:0] mem0 [256];
   logic [31:0] mem1 [256];
   logic [31:0] refm [2][256];
   logic        bd_we = 1'b0;
   logic [7:0]  bd_idx;
   logic [31:0] bd_data;

   assign if0.mem_rdata = mem0[if0.mem_adr[9:2]];
   assign if1.mem_rdata = mem1[if1.mem_adr[9:2]];

   always @(posedge clk) begin
      if (bd_we) begin
         mem0[bd_idx] <= bd_data;
         mem1[bd_idx] <= bd_data;
      end else begin
         if (if0.mem_write) mem0[if0.mem_adr[9:2]] <= if0.mem_wdata;
         if (if1.mem_write) mem1[if1.mem_adr[9:2]] <= if1.mem_wdata;
      end
   end

   int n_pass = 0;
   int n_tot = 0;
   logic [31:0] g_rd [2];
   logic [31:0] e_rd [2];
   logic        g_mis [2];
   logic        e_mis [2];
   int g_lat [2];
   int e_lat [2];
   int g_rdc [2];
   int e_rdc [2];
   int g_wrc [2];
   int e_wrc [2];
   int g_bad [2];
   logic act [2];

   typedef struct {
      logic        we;
      logic [1:0]  sz;
      logic        uns;
      logic [31:0] a;
      logic [31:0] wd;
      logic [31:0] init;
      logic [31:0] x_rd;
      logic [31:0] x_mem;
      logic        x_mis;
      int          x_lat;
   } vec_t;
   vec_t tbl [15];

   task automatic check(input string n, input logic [31:0] got, input logic [31:0] exp);
      n_tot++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", n, got, exp);
   endtask

   // reference: spec rules expressed with shifts and masks on the whole word
   function automatic void model(input int d, input logic we, input logic [1:0] sz, input logic uns,
                                 input logic [31:0] a, input logic [31:0] wd);
      int w;
      int sh;
      logic ac;
      logic [31:0] word;
      logic [31:0] mask;
      logic [31:0] v;
      w = d != 0 ? 2 : 0;
      ac = d == 0;
      word = refm[d][a[9:2]];
      e_mis[d] = ac && ((sz == 2'd1 && a[0]) || (sz >= 2'd2 && a[1:0] != 2'd0));
      e_rd[d] = 32'd0;
      e_rdc[d] = 0;
      e_wrc[d] = 0;
      if (!e_mis[d]) begin
         e_rdc[d] = (!we || sz < 2'd2) ? w + 1 : 0;
         e_wrc[d] = we ? w + 1 : 0;
         if (sz >= 2'd2) begin
            if (we) word = wd;
            else e_rd[d] = word;
         end else begin
            sh = sz == 2'd0 ? 8 * int'(a[1:0]) : 16 * int'(a[1]);
            mask = sz == 2'd0 ? 32'hFF : 32'hFFFF;
            if (we) word = (word & ~(mask << sh)) | ((wd & mask) << sh);
            else begin
               v = (word >> sh) & mask;
               if (!uns && v > (mask >> 1)) v = v - mask - 32'd1;
               e_rd[d] = v;
            end
         end
      end
      e_lat[d] = 1 + e_rdc[d] + e_wrc[d];
      refm[d][a[9:2]] = word;
   endfunction

   function automatic logic obs(input int d, input int cyc, input logic [31:0] a, input logic st,
                                input logic rv, input logic ms, input logic mr, input logic mw,
                                input logic [31:0] rd, input logic [31:0] adr);
      if (!act[d]) return 1'b0;
      if (ms && !rv) g_bad[d]++;
      if (mr && mw) g_bad[d]++;
      if ((mr || mw) && adr != {a[31:2], 2'b00}) g_bad[d]++;
      g_rdc[d] += int'(mr);
      g_wrc[d] += int'(mw);
      if (rv) begin
         if (st || mr || mw) g_bad[d]++;
         g_lat[d] = cyc - 1;
         g_mis[d] = ms;
         g_rd[d] = rd;
         act[d] = 1'b0;
         return 1'b1;
      end
      if (!st) g_bad[d]++;
      return 1'b0;
   endfunction

   task automatic drive(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd);
      if0.req_we = we; if0.req_size = sz; if0.req_unsigned = uns; if0.req_addr = a; if0.req_wdata = wd;
      if1.req_we = we; if1.req_size = sz; if1.req_unsigned = uns; if1.req_addr = a; if1.req_wdata = wd;
      if0.req_valid = 1'b1;
      if1.req_valid = 1'b1;
   endtask

   task automatic run(input logic we, input logic [1:0] sz, input logic uns,
                      input logic [31:0] a, input logic [31:0] wd);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         g_lat[d] = -1; g_rdc[d] = 0; g_wrc[d] = 0; g_bad[d] = 0;
         g_rd[d] = 32'hDEAD_DEAD; g_mis[d] = 1'b0; act[d] = 1'b1;
      end
      drive(we, sz, uns, a, wd);
      #1;
      for (int c = 1; c <= 40 && (act[0] || act[1]); c++) begin
         if (c > 1) begin
            @(negedge clk);
            #1;
         end
         if (obs(0, c, a, if0.stall, if0.rsp_valid, if0.misalign, if0.mem_read, if0.mem_write,
                 if0.rsp_rdata, if0.mem_adr)) if0.req_valid = 1'b0;
         if (obs(1, c, a, if1.stall, if1.rsp_valid, if1.misalign, if1.mem_read, if1.mem_write,
                 if1.rsp_rdata, if1.mem_adr)) if1.req_valid = 1'b0;
      end
      if0.req_valid = 1'b0;
      if1.req_valid = 1'b0;
   endtask

   task automatic go(input logic we, input logic [1:0] sz, input logic uns,
                     input logic [31:0] a, input logic [31:0] wd);
      model(0, we, sz, uns, a, wd);
      model(1, we, sz, uns, a, wd);
      run(we, sz, uns, a, wd);
   endtask

   task automatic chk(input string t, input int d, input logic [31:0] a);
      check({t, "_rdata"}, g_rd[d], e_rd[d]);
      check({t, "_misalign"}, 32'(g_mis[d]), 32'(e_mis[d]));
      check({t, "_latency"}, 32'(g_lat[d]), 32'(e_lat[d]));
      check({t, "_rd_cycles"}, 32'(g_rdc[d]), 32'(e_rdc[d]));
      check({t, "_wr_cycles"}, 32'(g_wrc[d]), 32'(e_wrc[d]));
      check({t, "_protocol"}, 32'(g_bad[d]), 32'd0);
      check({t, "_mem"}, d != 0 ? mem1[a[9:2]] : mem0[a[9:2]], refm[d][a[9:2]]);
   endtask

   task automatic poke(input logic [7:0] idx, input logic [31:0] data);
      @(negedge clk);
      bd_we = 1'b1;
      bd_idx = idx;
      bd_data = data;
      @(posedge clk);
      #1 bd_we = 1'b0;
      refm[0][idx] = data;
      refm[1][idx] = data;
   endtask

   initial begin
      int n;
      tbl[0]  = '{1'b0, 2'd0, 1'b0, 32'h2004, 32'h0, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 2};
      tbl[0].sz = 2'd2;
      tbl[1]  = '{1'b0, 2'd0, 1'b0, 32'h2007, 32'h0, 32'h80FF1234, 32'hFFFFFF80, 32'h80FF1234, 1'b0, 2};
      tbl[2]  = '{1'b0, 2'd0, 1'b1, 32'h2007, 32'h0, 32'h80FF1234, 32'h00000080, 32'h80FF1234, 1'b0, 2};
      tbl[3]  = '{1'b1, 2'd0, 1'b0, 32'h2005, 32'hAB, 32'h11223344, 32'h0, 32'h1122AB44, 1'b0, 3};
      tbl[4]  = '{1'b1, 2'd1, 1'b0, 32'h2003, 32'hBEEF, 32'h11223344, 32'h0, 32'h11223344, 1'b1, 1};
      tbl[5]  = '{1'b1, 2'd2, 1'b0, 32'h2010, 32'hCAFEF00D, 32'h0, 32'h0, 32'hCAFEF00D, 1'b0, 2};
      tbl[6]  = '{1'b0, 2'd1, 1'b0, 32'h2002, 32'h0, 32'h80017FFF, 32'hFFFF8001, 32'h80017FFF, 1'b0, 2};
      tbl[7]  = '{1'b0, 2'd1, 1'b1, 32'h2002, 32'h0, 32'h80017FFF, 32'h00008001, 32'h80017FFF, 1'b0, 2};
      tbl[8]  = '{1'b0, 2'd1, 1'b0, 32'h2000, 32'h0, 32'h80017FFF, 32'h00007FFF, 32'h80017FFF, 1'b0, 2};
      tbl[9]  = '{1'b0, 2'd2, 1'b0, 32'h2001, 32'h0, 32'h12345678, 32'h0, 32'h12345678, 1'b1, 1};
      tbl[10] = '{1'b1, 2'd1, 1'b0, 32'h2006, 32'h12345678, 32'hAABBCCDD, 32'h0, 32'h5678CCDD, 1'b0, 3};
      tbl[11] = '{1'b0, 2'd3, 1'b0, 32'h2008, 32'h0, 32'h01020304, 32'h01020304, 32'h01020304, 1'b0, 2};
      tbl[12] = '{1'b1, 2'd0, 1'b0, 32'h2000, 32'hFF, 32'h0, 32'h0, 32'h000000FF, 1'b0, 3};
      tbl[13] = '{1'b1, 2'd0, 1'b0, 32'h2003, 32'h5A, 32'hFFFFFFFF, 32'h0, 32'h5AFFFFFF, 1'b0, 3};
      tbl[14] = '{1'b0, 2'd0, 1'b0, 32'h2001, 32'h0, 32'h00007F00, 32'h0000007F, 32'h00007F00, 1'b0, 2};

      rst = 1'b1;
      if0.req_valid = 1'b0; if0.req_we = 1'b0; if0.req_size = 2'd0; if0.req_unsigned = 1'b0;
      if0.req_addr = 32'd0; if0.req_wdata = 32'd0;
      if1.req_valid = 1'b0; if1.req_we = 1'b0; if1.req_size = 2'd0; if1.req_unsigned = 1'b0;
      if1.req_addr = 32'd0; if1.req_wdata = 32'd0;
      repeat (2) @(negedge clk);
      check("reset_ctl0", {27'd0, if0.stall, if0.rsp_valid, if0.misalign, if0.mem_read, if0.mem_write}, 32'd0);
      check("reset_ctl1", {27'd0, if1.stall, if1.rsp_valid, if1.misalign, if1.mem_read, if1.mem_write}, 32'd0);
      check("reset_adr", if0.mem_adr, 32'd0);
      check("reset_wdata", if0.mem_wdata, 32'd0);
      check("reset_rdata", if0.rsp_rdata, 32'd0);
      rst = 1'b0;
      for (int i = 0; i < 256; i++) poke(8'(i), 32'd0);

      for (int i = 0; i < 15; i++) begin
         poke(tbl[i].a[9:2], tbl[i].init);
         go(tbl[i].we, tbl[i].sz, tbl[i].uns, tbl[i].a, tbl[i].wd);
         check($sformatf("vec%0d_rdata", i), g_rd[0], tbl[i].x_rd);
         check($sformatf("vec%0d_misalign", i), 32'(g_mis[0]), 32'(tbl[i].x_mis));
         check($sformatf("vec%0d_latency", i), 32'(g_lat[0]), 32'(tbl[i].x_lat));
         check($sformatf("vec%0d_mem", i), mem0[tbl[i].a[9:2]], tbl[i].x_mem);
         chk($sformatf("vec%0d_d0", i), 0, tbl[i].a);
         chk($sformatf("vec%0d_d1", i), 1, tbl[i].a);
      end

      // slow instance: word store holds mem_write 3 cycles, stall 4 incl. accept
      go(1'b1, 2'd2, 1'b0, 32'h2010, 32'h0BADCAFE);
      check("w2_sw_wr_cycles", 32'(g_wrc[1]), 32'd3);
      check("w2_sw_latency", 32'(g_lat[1]), 32'd4);
      check("w2_sw_mem", mem1[8'h04], 32'h0BADCAFE);
      // force-align instance: sh 0x2003 writes lanes 2-3
      poke(8'h00, 32'h11223344);
      go(1'b1, 2'd1, 1'b0, 32'h2003, 32'h0000BEEF);
      check("noalign_sh_mem", mem1[8'h00], 32'hBEEF3344);
      check("noalign_sh_mis", 32'(g_mis[1]), 32'd0);
      check("align_sh_untouched", mem0[8'h00], 32'h11223344);
      // rsp_rdata holds the last load value while idle
      poke(8'h02, 32'h89ABCDEF);
      go(1'b0, 2'd1, 1'b0, 32'h2008, 32'h0);
      @(negedge clk);
      @(negedge clk);
      check("rdata_hold", if0.rsp_rdata, 32'hFFFFCDEF);

      for (int i = 0; i < 150; i++) begin
         logic we;
         logic [1:0] sz;
         logic uns;
         logic [31:0] a;
         logic [31:0] wd;
         we = 1'($urandom_range(0, 1));
         sz = 2'($urandom_range(0, 3));
         uns = 1'($urandom_range(0, 1));
         a = $urandom();
         wd = $urandom();
         go(we, sz, uns, a, wd);
         chk($sformatf("rnd%0d_d0", i), 0, a);
         chk($sformatf("rnd%0d_d1", i), 1, a);
      end

      // reset in the middle of a byte-store read-modify-write
      poke(8'h01, 32'h11223344);
      @(negedge clk);
      drive(1'b1, 2'd0, 1'b0, 32'h2005, 32'hAB);
      #1;
      n = 0;
      while (!if0.mem_write && n < 10) begin
         @(negedge clk);
         #1;
         n++;
      end
      check("rst_wr_reached", 32'(if0.mem_write), 32'd1);
      if0.req_valid = 1'b0;
      if1.req_valid = 1'b0;
      rst = 1'b1;
      #1;
      check("rst_wr_drop", 32'(if0.mem_write), 32'd0);
      check("rst_rd_drop", 32'(if1.mem_read), 32'd0);
      check("rst_stall", 32'(if0.stall), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      #1;
      check("rst_mem0_kept", mem0[8'h01], 32'h11223344);
      check("rst_mem1_kept", mem1[8'h01], 32'h11223344);
      check("rst_idle", {30'd0, if0.rsp_valid, if0.stall}, 32'd0);
      check("rst_rdata_clr", if0.rsp_rdata, 32'd0);
      go(1'b0, 2'd0, 1'b1, 32'h2005, 32'h0);
      check("post_rst_lbu", g_rd[0], 32'h00000033);
      chk("post_rst_d0", 0, 32'h2005);
      chk("post_rst_d1", 1, 32'h2005);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule
